// File: rtl/exp_cmd_pkg.sv
// Shared opcodes, FSM states and status-word layout for the experiment command executor.
package exp_cmd_pkg;
  localparam logic [7:0] OP_NOP     = 8'h00;
  localparam logic [7:0] OP_SET_CFG = 8'h01;
  localparam logic [7:0] OP_GET_CFG = 8'h02;
  localparam logic [7:0] OP_SET_DT  = 8'h03;
  localparam logic [7:0] OP_CLR_ST  = 8'h04;

  localparam int ST_BUSY    = 31;
  localparam int ST_ERR     = 30;
  localparam int ST_OVR     = 29;
  localparam int ST_SEQ_LSB = 16;

  typedef enum logic [2:0] {
    S_IDLE, S_DECODE, S_BREAK, S_DEAD, S_MAKE, S_EXEC, S_DONE
  } state_e;
endpackage

// File: rtl/exp_dead_timer.sv
// Loadable down-counter timing the break-before-make gap; o_done flags a count of 1.
module exp_dead_timer #(
  parameter int DT_W = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_load,
  input  logic            i_en,
  input  logic [DT_W-1:0] i_val,
  output logic            o_done
);
  logic [DT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_load)                 cnt_d = i_val;
    else if (i_en && cnt_q != '0) cnt_d = cnt_q - DT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign o_done = (cnt_q == DT_W'(1));
endmodule

// File: rtl/experiment_cmd_exec.sv
// Executes one latched command per commit edge; drives power switches break-before-make.
// Optional build macro EXP_SAFE_MASK_EN rejects SET_CFG patterns outside SAFE_MASK.
module experiment_cmd_exec
  import exp_cmd_pkg::*;
#(
  parameter int             NSW              = 16,
  parameter int             DT_W             = 16,
  parameter int             DEADTIME_DEFAULT = 8,
  parameter logic [NSW-1:0] SAFE_MASK        = {NSW{1'b1}}
) (
  input  logic           S_AXI_ACLK,
  input  logic           i_reset,
  input  logic [31:0]    i_command,
  input  logic [31:0]    i_data,
  input  logic           i_commit,
  output logic [31:0]    o_data_in,
  output logic [NSW-1:0] o_sw,
  output logic           o_busy
);
  state_e          state_q, state_d;
  logic            commit_q;
  logic [7:0]      op_q, op_d;
  logic [31:0]     data_q, data_d;
  logic [NSW-1:0]  sw_q, sw_d;
  logic [DT_W-1:0] dt_q, dt_d;
  logic            busy_q, busy_d, err_q, err_d, ovr_q, ovr_d;
  logic [11:0]     seq_q, seq_d;
  logic [15:0]     res_q, res_d;

  logic            cmt_edge, cfg_rej, tmr_done;
  logic [NSW-1:0]  new_cfg;
  logic [DT_W-1:0] dt_load;

  assign cmt_edge = i_commit & ~commit_q;
  assign new_cfg  = data_q[NSW-1:0];
  // A zero dead time still gets one cycle of break.
  assign dt_load  = (dt_q == '0) ? DT_W'(1) : dt_q;

`ifdef EXP_SAFE_MASK_EN
  assign cfg_rej = |(new_cfg & ~SAFE_MASK);
`else
  assign cfg_rej = 1'b0;
`endif

  // Operand/opcode bits beyond what the decoder consumes, plus the mask in the default build.
  logic unused_bits;
  assign unused_bits = ^{i_command[31:8], data_q, SAFE_MASK};

  exp_dead_timer #(.DT_W(DT_W)) u_dead (
    .clk    (S_AXI_ACLK),
    .rst    (i_reset),
    .i_load (state_q == S_BREAK),
    .i_en   (state_q == S_DEAD),
    .i_val  (dt_load),
    .o_done (tmr_done)
  );

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    data_d  = data_q;
    sw_d    = sw_q;
    dt_d    = dt_q;
    busy_d  = busy_q;
    err_d   = err_q;
    ovr_d   = ovr_q;
    seq_d   = seq_q;
    res_d   = res_q;
    case (state_q)
      S_IDLE: if (cmt_edge) begin
        op_d    = i_command[7:0];
        data_d  = i_data;
        busy_d  = 1'b1;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        if (op_q == OP_SET_CFG && !cfg_rej)
          state_d = (new_cfg == sw_q) ? S_MAKE : S_BREAK;
        else
          state_d = S_EXEC;
      end
      S_BREAK: begin
        sw_d    = sw_q & new_cfg;
        state_d = S_DEAD;
      end
      // The new pattern lands on the edge leaving DEAD so the gap is exactly the dead time.
      S_DEAD: if (tmr_done) begin
        sw_d    = new_cfg;
        state_d = S_MAKE;
      end
      S_MAKE: state_d = S_DONE;
      S_EXEC: begin
        if (op_q == OP_SET_DT) dt_d = data_q[DT_W-1:0];
        state_d = S_DONE;
      end
      S_DONE: begin
        seq_d   = seq_q + 12'd1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
        case (op_q)
          OP_NOP:     ;
          OP_SET_CFG: if (cfg_rej) err_d = 1'b1;
          OP_GET_CFG: res_d = 16'(sw_q);
          OP_SET_DT:  res_d = 16'(dt_q);
          OP_CLR_ST:  begin err_d = 1'b0; ovr_d = 1'b0; end
          default:    err_d = 1'b1;
        endcase
      end
      default: state_d = S_IDLE;
    endcase
    // Overrun is evaluated last so it wins over a coincident CLR_ST.
    if (cmt_edge && state_q != S_IDLE) ovr_d = 1'b1;
  end

  always_ff @(posedge S_AXI_ACLK or posedge i_reset) begin
    if (i_reset) begin
      state_q  <= S_IDLE;
      commit_q <= 1'b0;
      op_q     <= '0;
      data_q   <= '0;
      sw_q     <= '0;
      dt_q     <= DT_W'(DEADTIME_DEFAULT);
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
      ovr_q    <= 1'b0;
      seq_q    <= '0;
      res_q    <= '0;
    end else begin
      state_q  <= state_d;
      commit_q <= i_commit;
      op_q     <= op_d;
      data_q   <= data_d;
      sw_q     <= sw_d;
      dt_q     <= dt_d;
      busy_q   <= busy_d;
      err_q    <= err_d;
      ovr_q    <= ovr_d;
      seq_q    <= seq_d;
      res_q    <= res_d;
    end
  end

  always_comb begin
    o_data_in                         = '0;
    o_data_in[ST_BUSY]                = busy_q;
    o_data_in[ST_ERR]                 = err_q;
    o_data_in[ST_OVR]                 = ovr_q;
    o_data_in[ST_SEQ_LSB+11:ST_SEQ_LSB] = seq_q;
    o_data_in[15:0]                   = res_q;
  end

  assign o_sw   = sw_q;
  assign o_busy = busy_q;
endmodule

// File: tb/tb_experiment_cmd_exec.sv
// Directed bench: a vector table of single commands, then multi-cycle dead-time/overrun/reset sequences.
module tb_experiment_cmd_exec;
  import exp_cmd_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        commit;
  logic [31:0] cmd, data;
  logic [31:0] dout;
  logic [15:0] sw;
  logic        busy;
  int          checks = 0, failures = 0;
  int          cnt;

  typedef struct {
    logic [31:0] cmd;
    logic [31:0] data;
    logic [15:0] sw;
    logic [31:0] st;
  } vec_t;
  vec_t vecs[12];

  experiment_cmd_exec #(
    .NSW(16), .DT_W(16), .DEADTIME_DEFAULT(8), .SAFE_MASK(16'h00FF)
  ) dut (
    .S_AXI_ACLK (clk),
    .i_reset    (rst),
    .i_command  (cmd),
    .i_data     (data),
    .i_commit   (commit),
    .o_data_in  (dout),
    .o_sw       (sw),
    .o_busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic start_cmd(input logic [31:0] c, input logic [31:0] d);
    @(negedge clk);
    cmd = c; data = d; commit = 1'b1;
    @(negedge clk);
    commit = 1'b0;
  endtask

  // Counts cycles o_sw equals 'watch' until busy drops.
  task automatic wait_idle(input logic [15:0] watch, output int n);
    n = 0;
    for (int i = 0; i < 200; i++) begin
      if (!busy) return;
      if (sw == watch) n++;
      @(negedge clk);
    end
    checks++; failures++;
    $display("FAIL busy_timeout actual=busy expected=idle");
  endtask

  task automatic do_cmd(input logic [31:0] c, input logic [31:0] d,
                        input logic [15:0] watch, output int n);
    start_cmd(c, d);
    wait_idle(watch, n);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_sw", {16'h0, sw}, 32'h0);
    chk("rst_status", dout, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; commit = 1'b0; cmd = '0; data = '0;
    vecs[0]  = '{32'h0000_0002, 32'h0,       16'h0000, 32'h0001_0000};
    vecs[1]  = '{32'h0000_0001, 32'h00A5,    16'h00A5, 32'h0002_0000};
    vecs[2]  = '{32'h0000_0002, 32'h0,       16'h00A5, 32'h0003_00A5};
    vecs[3]  = '{32'h0000_0003, 32'h5,       16'h00A5, 32'h0004_0005};
    vecs[4]  = '{32'h0000_007F, 32'h0,       16'h00A5, 32'h4005_0005};
    vecs[5]  = '{32'h0000_0000, 32'h0,       16'h00A5, 32'h4006_0005};
    vecs[6]  = '{32'h0000_0004, 32'h0,       16'h00A5, 32'h0007_0005};
    vecs[7]  = '{32'h0000_0001, 32'h00A5,    16'h00A5, 32'h0008_0005};
    vecs[8]  = '{32'h0000_0003, 32'h1_2345,  16'h00A5, 32'h0009_2345};
    vecs[9]  = '{32'h0000_0003, 32'h2,       16'h00A5, 32'h000A_0002};
    vecs[10] = '{32'hFFFF_FF02, 32'h0,       16'h00A5, 32'h000B_00A5};
`ifdef EXP_SAFE_MASK_EN
    vecs[11] = '{32'h0000_0001, 32'h0100,    16'h00A5, 32'h400C_00A5};
`else
    vecs[11] = '{32'h0000_0001, 32'h0100,    16'h0100, 32'h000C_00A5};
`endif

    do_reset();
    for (int i = 0; i < 12; i++) begin
      do_cmd(vecs[i].cmd, vecs[i].data, 16'hFFFF, cnt);
      chk($sformatf("vec%0d_sw", i), {16'h0, sw}, {16'h0, vecs[i].sw});
      chk($sformatf("vec%0d_status", i), dout, vecs[i].st);
    end

    // Dead time of 3: F -> F0 breaks to 0 for exactly 3 cycles.
    do_reset();
    do_cmd({24'h0, OP_SET_DT}, 32'd3, 16'hFFFF, cnt);
    do_cmd({24'h0, OP_SET_CFG}, 32'h000F, 16'hFFFF, cnt);
    do_cmd({24'h0, OP_SET_CFG}, 32'h00F0, 16'h0000, cnt);
    chk("dt3_gap", cnt, 3);
    chk("dt3_sw", {16'h0, sw}, 32'h00F0);
    chk("dt3_status", dout, 32'h0003_0003);

    // Dead time 0 still gives one break cycle: 3 -> 6 shows 2 once.
    do_cmd({24'h0, OP_SET_CFG}, 32'h0003, 16'hFFFF, cnt);
    do_cmd({24'h0, OP_SET_DT}, 32'd0, 16'hFFFF, cnt);
    do_cmd({24'h0, OP_SET_CFG}, 32'h0006, 16'h0002, cnt);
    chk("dt0_gap", cnt, 1);
    chk("dt0_sw", {16'h0, sw}, 32'h0006);

    // Illegal opcode then clear.
    do_cmd(32'h0000_007F, 32'h0, 16'hFFFF, cnt);
    chk("bad_op_err", {31'h0, dout[ST_ERR]}, 32'h1);
    chk("bad_op_sw", {16'h0, sw}, 32'h0006);
    do_cmd({24'h0, OP_CLR_ST}, 32'h0, 16'hFFFF, cnt);
    chk("clr_status", dout, 32'h0008_0000);

    // Second edge during DEAD is an overrun; held level does not retrigger.
    do_cmd({24'h0, OP_SET_DT}, 32'd20, 16'hFFFF, cnt);
    start_cmd({24'h0, OP_SET_CFG}, 32'h00F0);
    repeat (5) @(negedge clk);
    commit = 1'b1;
    wait_idle(16'hFFFF, cnt);
    chk("ovr_sw", {16'h0, sw}, 32'h00F0);
    chk("ovr_status", dout, 32'h200A_0014);
    repeat (3) @(negedge clk);
    chk("held_busy", {31'h0, busy}, 32'h0);
    chk("held_status", dout, 32'h200A_0014);
    commit = 1'b0;

    // Asynchronous reset in the middle of DEAD.
    start_cmd({24'h0, OP_SET_CFG}, 32'h000F);
    repeat (6) @(negedge clk);
    chk("pre_rst_busy", {31'h0, busy}, 32'h1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_sw", {16'h0, sw}, 32'h0);
    chk("async_rst_status", dout, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    do_cmd({24'h0, OP_GET_CFG}, 32'h0, 16'hFFFF, cnt);
    chk("post_rst_get", dout, 32'h0001_0000);
    do_cmd({24'h0, OP_SET_CFG}, 32'h0003, 16'hFFFF, cnt);
    do_cmd({24'h0, OP_SET_CFG}, 32'h0006, 16'h0002, cnt);
    chk("post_rst_dt_default", cnt, 8);
    chk("post_rst_sw", {16'h0, sw}, 32'h0006);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
